cnn_cell_update: RTL and testbench

Sequential state-update engine for one cellular-neural-network cell. It accumulates the 3x3 feedback template products A·y and the control template products B·u one tap per cycle, forms dX = A·y + B·u + bias − X, and applies one forward-Euler step to the cell state. It then emits the new state together with the saturated cell output 0.5(|X+1| − |X−1|). It is the producer side of the cell's output function: it generates the dX/X that the output stage consumes, and it closes the loop by computing the next state from neighbour outputs.

---
 rtl/cnn_pkg.sv | 42 ++++
 rtl/cnn_tap_mac.sv | 22 ++
 rtl/cnn_cell_update.sv | 120 ++++++++++++
 tb/tb_cnn_cell_update.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN cell state-update engine.
// Helpers work on accumulator-width values so callers truncate only once.
package cnn_pkg;

    localparam int CNN_WIDTH     = 9;
    localparam int CNN_FRAC      = 4;
    localparam int CNN_ACC_WIDTH = 24;
    localparam int CNN_TAPS      = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        UPDATE,
        OUTPUT
    } state_t;

    // Saturate to the signed range of a w-bit value.
    function automatic logic signed [CNN_ACC_WIDTH-1:0] sat_width(
        input logic signed [CNN_ACC_WIDTH-1:0] v,
        input int                              w
    );
        logic signed [CNN_ACC_WIDTH-1:0] hi;
        logic signed [CNN_ACC_WIDTH-1:0] lo;
        hi = (CNN_ACC_WIDTH'(1) <<< (w - 1)) - CNN_ACC_WIDTH'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [CNN_ACC_WIDTH-1:0] clamp_unit(
        input logic signed [CNN_ACC_WIDTH-1:0] v,
        input int                              frac
    );
        logic signed [CNN_ACC_WIDTH-1:0] one;
        one = CNN_ACC_WIDTH'(1) <<< frac;
        if (v > one) return one;
        if (v < -one) return -one;
        return v;
    endfunction

endpackage

// File: rtl/cnn_tap_mac.sv
// Combinational two-product adder a*y + b*u for one template tap.
// Products are full 2*WIDTH signed; the sum carries one extra bit.
module cnn_tap_mac
    import cnn_pkg::*;
#(
    parameter int WIDTH = CNN_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic signed [WIDTH-1:0] u_i,
    output logic signed [2*WIDTH:0] sum_o
);

    logic signed [2*WIDTH-1:0] p_ay;
    logic signed [2*WIDTH-1:0] p_bu;

    assign p_ay  = (2*WIDTH)'(a_i) * (2*WIDTH)'(y_i);
    assign p_bu  = (2*WIDTH)'(b_i) * (2*WIDTH)'(u_i);
    assign sum_o = (2*WIDTH+1)'(p_ay) + (2*WIDTH+1)'(p_bu);

endmodule

// File: rtl/cnn_cell_update.sv
// One forward-Euler state update of a CNN cell: accumulates A*y + B*u one tap
// per cycle, then X += (acc/ONE + bias - X) * dt with saturation.
module cnn_cell_update
    import cnn_pkg::*;
#(
    parameter int WIDTH     = CNN_WIDTH,
    parameter int FRAC      = CNN_FRAC,
    parameter int TSHIFT    = 3,
    parameter int ACC_WIDTH = CNN_ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] x_init,
    input  logic signed [WIDTH-1:0] bias,
    input  logic [9*WIDTH-1:0]      a_tmpl,
    input  logic [9*WIDTH-1:0]      b_tmpl,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] y_nb,
    input  logic signed [WIDTH-1:0] u_nb,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic                    busy
);

    state_t                      state_q;
    logic [3:0]                  tap_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0]     x_q;
    logic signed [WIDTH-1:0]     bias_q;
    logic signed [WIDTH-1:0]     x_out_q;
    logic signed [WIDTH-1:0]     y_out_q;
    logic                        out_valid_q;

    logic signed [WIDTH-1:0]     a_k;
    logic signed [WIDTH-1:0]     b_k;
    logic signed [2*WIDTH:0]     mac_sum;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] s_d;
    logic signed [ACC_WIDTH-1:0] xsum_d;
    logic signed [WIDTH-1:0]     x_d;
    logic signed [WIDTH-1:0]     y_d;

    assign a_k = a_tmpl[tap_q*WIDTH +: WIDTH];
    assign b_k = b_tmpl[tap_q*WIDTH +: WIDTH];

    cnn_tap_mac #(.WIDTH(WIDTH)) u_mac (
        .a_i  (a_k),
        .y_i  (y_nb),
        .b_i  (b_k),
        .u_i  (u_nb),
        .sum_o(mac_sum)
    );

    // Shifts are arithmetic, so both divisions round toward minus infinity.
    always_comb begin
        acc_d  = acc_q + ACC_WIDTH'(mac_sum);
        s_d    = (acc_q >>> FRAC) + ACC_WIDTH'(bias_q) - ACC_WIDTH'(x_q);
        xsum_d = ACC_WIDTH'(x_q) + (s_d >>> TSHIFT);
        x_d    = WIDTH'(sat_width(CNN_ACC_WIDTH'(xsum_d), WIDTH));
        y_d    = WIDTH'(clamp_unit(CNN_ACC_WIDTH'(x_d), FRAC));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            bias_q      <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        tap_q   <= '0;
                        bias_q  <= bias;
                        if (load) x_q <= x_init;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        tap_q <= tap_q + 4'd1;
                        if (tap_q == 4'(CNN_TAPS - 1)) state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    x_q         <= x_d;
                    x_out_q     <= x_d;
                    y_out_q     <= y_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;

endmodule

// File: tb/tb_cnn_cell_update.sv
// Randomized scoreboard bench for cnn_cell_update against a plain-arithmetic
// model of the Euler step.
module tb_cnn_cell_update;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              load;
    logic signed [8:0] x_init;
    logic signed [8:0] bias;
    logic [80:0]       a_tmpl;
    logic [80:0]       b_tmpl;
    logic              in_valid;
    logic              in_ready;
    logic signed [8:0] y_nb;
    logic signed [8:0] u_nb;
    logic              out_valid;
    logic              out_ready;
    logic signed [8:0] x_out;
    logic signed [8:0] y_out;
    logic              busy;

    cnn_cell_update dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load     (load),
        .x_init   (x_init),
        .bias     (bias),
        .a_tmpl   (a_tmpl),
        .b_tmpl   (b_tmpl),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_nb     (y_nb),
        .u_nb     (u_nb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mx     = 0;
    int last_x = 0;
    int last_y = 0;
    int ta[9];
    int tbw[9];
    int ty[9];
    int tu[9];
    int exp_x[$];
    int exp_y[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int rs();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: X' = sat(X + floor((floor(sum/16) + I - X) / 8)), Y = clamp(X', -16, 16)
    task automatic model_step(input bit ld, input int xin, input int bi);
        int acc;
        int s;
        int xn;
        if (ld) mx = xin;
        acc = 0;
        for (int k = 0; k < 9; k++) acc += ta[k] * ty[k] + tbw[k] * tu[k];
        s  = fdiv(acc, 16) + bi - mx;
        xn = clampi(mx + fdiv(s, 8), -256, 255);
        mx = xn;
        exp_x.push_back(xn);
        exp_y.push_back(clampi(xn, -16, 16));
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_x.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got output x=%0d y=%0d, expected no output", x_out, y_out);
            end else begin
                chk("sb_x", int'(x_out), exp_x.pop_front());
                chk("sb_y", int'(y_out), exp_y.pop_front());
                last_x = int'(x_out);
                last_y = int'(y_out);
            end
        end
    end

    task automatic set_zero();
        for (int k = 0; k < 9; k++) begin
            ta[k] = 0; tbw[k] = 0; ty[k] = 0; tu[k] = 0;
        end
    endtask

    task automatic set_center();
        set_zero();
        ta[4] = 32;
        ty[4] = 16;
    endtask

    task automatic send_tap(input int k);
        int w;
        w = 0;
        in_valid = 1'b1;
        y_nb = 9'(ty[k]);
        u_nb = 9'(tu[k]);
        @(negedge clk);
        while (!in_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("tap_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_step(input bit ld, input int xin, input int bi, input bit gaps,
                           input bit bstart, input bit hold, input int abort_at);
        int w;
        int st;
        int hx;
        int hy;
        for (int k = 0; k < 9; k++) begin
            a_tmpl[k*9 +: 9] = 9'(ta[k]);
            b_tmpl[k*9 +: 9] = 9'(tbw[k]);
        end
        if (abort_at < 0) model_step(ld, xin, bi);
        w = 0;
        @(negedge clk);
        while (busy && w < 50) begin
            w++;
            @(negedge clk);
        end
        chk("idle_before_start", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b1; load = ld; x_init = 9'(xin); bias = 9'(bi);
        out_ready = !hold;
        @(posedge clk); #1;
        st = cyc;
        start = 1'b0; load = 1'b0;
        x_init = 9'(rs()); bias = 9'(rs());
        for (int k = 0; k < 9; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    y_nb = 9'(rs()); u_nb = 9'(rs());
                    @(posedge clk); #1;
                end
            end
            if (bstart && k == 2) begin
                start = 1'b1; load = 1'b1; x_init = -9'sd200;
            end
            send_tap(k);
            start = 1'b0; load = 1'b0;
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_busy", int'(busy), 0);
                chk("abort_in_ready", int'(in_ready), 0);
                chk("abort_out_valid", int'(out_valid), 0);
                chk("abort_x_out", int'(x_out), 0);
                mx = 0;
                return;
            end
        end
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("out_valid_seen", int'(out_valid), 1);
        // st is the start edge; out_valid first sampled high at edge st+11.
        if (!gaps) chk("latency", cyc - st + 1, 11);
        if (hold) begin
            hx = int'(x_out);
            hy = int'(y_out);
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_x", int'(x_out), hx);
                chk("hold_y", int'(y_out), hy);
                chk("hold_in_ready", int'(in_ready), 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        w = 0;
        @(negedge clk);
        while (busy && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("return_idle", int'(busy), 0);
        chk("out_valid_dropped", int'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        reset = 1'b1; start = 1'b0; load = 1'b0; x_init = '0; bias = '0;
        a_tmpl = '0; b_tmpl = '0; in_valid = 1'b0; y_nb = '0; u_nb = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);

        set_center();
        do_step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("center_x", last_x, 4);
        chk("center_y", last_y, 4);

        set_zero();
        do_step(1'b1, 100, 100, 1'b0, 1'b0, 1'b0, -1);
        chk("satpos_x", last_x, 100);
        chk("satpos_y", last_y, 16);
        do_step(1'b1, -100, -100, 1'b0, 1'b0, 1'b0, -1);
        chk("satneg_x", last_x, -100);
        chk("satneg_y", last_y, -16);

        do_step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        do_step(1'b0, 0, 80, 1'b0, 1'b0, 1'b0, -1);
        chk("conv_1", last_x, 10);
        do_step(1'b0, 0, 80, 1'b0, 1'b0, 1'b0, -1);
        chk("conv_2", last_x, 18);
        do_step(1'b0, 0, 80, 1'b0, 1'b0, 1'b0, -1);
        chk("conv_3", last_x, 25);
        for (int i = 0; i < 4; i++) begin
            prev = last_x;
            do_step(1'b0, 0, 80, 1'b0, 1'b0, 1'b0, -1);
            chk("conv_monotonic", int'(last_x > prev && last_x <= 80), 1);
        end

        for (int k = 0; k < 9; k++) begin
            ta[k] = 127; ty[k] = 127; tbw[k] = 0; tu[k] = 0;
        end
        do_step(1'b1, 255, 127, 1'b0, 1'b0, 1'b0, -1);
        chk("statesat_x", last_x, 255);
        chk("statesat_y", last_y, 16);

        set_center();
        do_step(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, -1);
        chk("gaps_x", last_x, 4);
        chk("gaps_y", last_y, 4);

        for (int k = 0; k < 9; k++) begin
            ta[k] = rs(); tbw[k] = rs(); ty[k] = rs(); tu[k] = rs();
        end
        do_step(1'b1, rs(), rs(), 1'b0, 1'b0, 1'b0, 4);
        set_center();
        do_step(1'b0, 123, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("post_reset_x", last_x, 4);
        chk("post_reset_y", last_y, 4);

        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 9; k++) begin
                ta[k] = rs(); tbw[k] = rs(); ty[k] = rs(); tu[k] = rs();
            end
            do_step($urandom_range(0, 3) == 0, rs(), rs(), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, -1);
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_x.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
